alu_issue_stage: RTL and testbench

Decode-to-execute pipeline register that feeds the ALU's `inputA`, `inputB` and `ALUSelect`. It resolves operand forwarding from the two downstream stages, detects load-use hazards, inserts bubbles and honours flush and back-pressure with a valid/ready handshake. It sits between the decoder/register-file read and the ALU/ComparisonUnit.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_issue_stage_if.sv | 52 +++++
 rtl/forward_mux.sv | 30 +++
 rtl/alu_issue_stage.sv | 103 ++++++++++
 tb/tb_alu_issue_stage.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand widths and the ALU select encoding.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package alu_pkg;

    localparam int dataWidth    = 32;
    localparam int selectWidth  = 4;
    localparam int regAddrWidth = 5;

    // ALU operation select; ADD is zero so a cleared pipeline register decodes as ADD.
    typedef enum logic [selectWidth-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_MUL  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_NOT  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_SLT  = 4'd10,
        ALU_SLTU = 4'd11
    } alu_sel_e;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Bundle of decode-side, downstream-side and execute-register signals of the issue stage.
// Latency: none (wiring only).
// Backpressure: id_ready returned to decode; ex_ready supplied by the ALU side.
interface alu_issue_stage_if;
    import alu_pkg::*;

    // decode side
    logic                    id_valid;
    logic                    id_ready;
    logic [regAddrWidth-1:0] id_rs1;
    logic [regAddrWidth-1:0] id_rs2;
    logic [dataWidth-1:0]    id_rs1Data;
    logic [dataWidth-1:0]    id_rs2Data;
    logic [dataWidth-1:0]    id_imm;
    logic                    id_useImm;
    logic [selectWidth-1:0]  id_aluSelect;
    logic [regAddrWidth-1:0] id_rd;
    logic                    id_regWrite;
    logic                    id_isLoad;

    // pipeline control and forwarding sources
    logic                    flush;
    logic                    ex_ready;
    logic [dataWidth-1:0]    ex_result;
    logic [regAddrWidth-1:0] mem_rd;
    logic                    mem_regWrite;
    logic [dataWidth-1:0]    mem_data;

    // registered execute-stage fields
    logic                    ex_valid;
    logic [dataWidth-1:0]    inputA;
    logic [dataWidth-1:0]    inputB;
    logic [selectWidth-1:0]  ALUSelect;
    logic [regAddrWidth-1:0] ex_rd;
    logic                    ex_regWrite;
    logic                    ex_isLoad;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1Data, id_rs2Data, id_imm, id_useImm,
               id_aluSelect, id_rd, id_regWrite, id_isLoad,
               flush, ex_ready, ex_result, mem_rd, mem_regWrite, mem_data,
        input  id_ready, ex_valid, inputA, inputB, ALUSelect, ex_rd, ex_regWrite, ex_isLoad
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1Data, id_rs2Data, id_imm, id_useImm,
               id_aluSelect, id_rd, id_regWrite, id_isLoad,
               flush, ex_ready, ex_result, mem_rd, mem_regWrite, mem_data,
        output id_ready, ex_valid, inputA, inputB, ALUSelect, ex_rd, ex_regWrite, ex_isLoad
    );

endinterface

// File: rtl/forward_mux.sv
// Selects one source operand: held instruction result, memory-stage value, or register file.
// Latency: combinational.
// Backpressure: none; the caller decides whether the result is captured.
module forward_mux
    import alu_pkg::*;
(
    input  logic [regAddrWidth-1:0] rs,
    input  logic [dataWidth-1:0]    rf_data,
    input  logic                    ex_fwd_en,
    input  logic [regAddrWidth-1:0] ex_rd,
    input  logic [dataWidth-1:0]    ex_result,
    input  logic                    mem_fwd_en,
    input  logic [regAddrWidth-1:0] mem_rd,
    input  logic [dataWidth-1:0]    mem_data,
    output logic [dataWidth-1:0]    operand
);

    // Youngest producer wins; x0 always takes the register-file value.
    always_comb begin
        operand = rf_data;
        if (rs != '0) begin
            if (ex_fwd_en && (ex_rd == rs)) begin
                operand = ex_result;
            end else if (mem_fwd_en && (mem_rd == rs)) begin
                operand = mem_data;
            end
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-to-execute register with operand forwarding, load-use bubble insertion and flush.
// Latency: 1 cycle from id_valid&&id_ready to ex_valid.
// Backpressure: holds all fields while ex_ready is low; id_ready drops on stall, hazard or flush.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    alu_issue_stage_if.slave   bus
);

    logic                    ex_valid_q;
    logic [dataWidth-1:0]    input_a_q;
    logic [dataWidth-1:0]    input_b_q;
    logic [selectWidth-1:0]  alu_select_q;
    logic [regAddrWidth-1:0] ex_rd_q;
    logic                    ex_reg_write_q;
    logic                    ex_is_load_q;

    logic                    hazard;
    logic                    ex_fwd_en;
    logic [dataWidth-1:0]    fwd_a;
    logic [dataWidth-1:0]    fwd_b;
    logic [dataWidth-1:0]    operand_b;
    logic                    capture;

    // A load's result is not available until it reaches the memory stage, so it
    // never forwards from the held slot; the hazard logic stalls the consumer instead.
    assign ex_fwd_en = ex_valid_q && ex_reg_write_q && !ex_is_load_q;

    // Load-use detection; rs2 is irrelevant when operand B comes from the immediate.
    always_comb begin
        hazard = 1'b0;
        if (ex_valid_q && ex_is_load_q && ex_reg_write_q && (ex_rd_q != '0)) begin
            hazard = (ex_rd_q == bus.id_rs1) || (!bus.id_useImm && (ex_rd_q == bus.id_rs2));
        end
    end

    assign bus.id_ready = bus.ex_ready && !hazard && !bus.flush;
    assign capture      = bus.ex_ready && bus.id_valid && !hazard;

    forward_mux u_fwd_a (
        .rs         (bus.id_rs1),
        .rf_data    (bus.id_rs1Data),
        .ex_fwd_en  (ex_fwd_en),
        .ex_rd      (ex_rd_q),
        .ex_result  (bus.ex_result),
        .mem_fwd_en (bus.mem_regWrite),
        .mem_rd     (bus.mem_rd),
        .mem_data   (bus.mem_data),
        .operand    (fwd_a)
    );

    forward_mux u_fwd_b (
        .rs         (bus.id_rs2),
        .rf_data    (bus.id_rs2Data),
        .ex_fwd_en  (ex_fwd_en),
        .ex_rd      (ex_rd_q),
        .ex_result  (bus.ex_result),
        .mem_fwd_en (bus.mem_regWrite),
        .mem_rd     (bus.mem_rd),
        .mem_data   (bus.mem_data),
        .operand    (fwd_b)
    );

    assign operand_b = bus.id_useImm ? bus.id_imm : fwd_b;

    // Pipeline register: flush kills, capture loads, a free slot bubbles, a stall holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid_q     <= 1'b0;
            input_a_q      <= '0;
            input_b_q      <= '0;
            alu_select_q   <= ALU_ADD;
            ex_rd_q        <= '0;
            ex_reg_write_q <= 1'b0;
            ex_is_load_q   <= 1'b0;
        end else if (bus.flush) begin
            ex_valid_q     <= 1'b0;
        end else if (capture) begin
            ex_valid_q     <= 1'b1;
            input_a_q      <= fwd_a;
            input_b_q      <= operand_b;
            alu_select_q   <= bus.id_aluSelect;
            ex_rd_q        <= bus.id_rd;
            ex_reg_write_q <= bus.id_regWrite;
            ex_is_load_q   <= bus.id_isLoad;
        end else if (bus.ex_ready) begin
            ex_valid_q     <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_is_load_q   <= 1'b0;
        end
    end

    assign bus.ex_valid    = ex_valid_q;
    assign bus.inputA      = input_a_q;
    assign bus.inputB      = input_b_q;
    assign bus.ALUSelect   = alu_select_q;
    assign bus.ex_rd       = ex_rd_q;
    assign bus.ex_regWrite = ex_reg_write_q;
    assign bus.ex_isLoad   = ex_is_load_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: forwarding, load-use bubble, x0 guard, stall, flush, reset.
// Latency: checks registered outputs 1 ns after each rising edge.
// Backpressure: ex_ready driven directly by the stimulus.
module tb_alu_issue_stage;
    import alu_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    alu_issue_stage_if bus ();

    alu_issue_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_instr(input logic [4:0] rs1, input logic [31:0] d1,
                               input logic [4:0] rs2, input logic [31:0] d2,
                               input logic use_imm, input logic [31:0] imm,
                               input logic [3:0] sel, input logic [4:0] rd,
                               input logic reg_write, input logic is_load);
        bus.id_valid     = 1'b1;
        bus.id_rs1       = rs1;
        bus.id_rs1Data   = d1;
        bus.id_rs2       = rs2;
        bus.id_rs2Data   = d2;
        bus.id_useImm    = use_imm;
        bus.id_imm       = imm;
        bus.id_aluSelect = sel;
        bus.id_rd        = rd;
        bus.id_regWrite  = reg_write;
        bus.id_isLoad    = is_load;
    endtask

    task automatic mem_set(input logic wr, input logic [4:0] rd, input logic [31:0] d);
        bus.mem_regWrite = wr;
        bus.mem_rd       = rd;
        bus.mem_data     = d;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ex_valid"},    {31'd0, bus.ex_valid},    32'd0);
        chk({tag, "_inputA"},      bus.inputA,               32'd0);
        chk({tag, "_inputB"},      bus.inputB,               32'd0);
        chk({tag, "_ALUSelect"},   {28'd0, bus.ALUSelect},   32'd0);
        chk({tag, "_ex_rd"},       {27'd0, bus.ex_rd},       32'd0);
        chk({tag, "_ex_regWrite"}, {31'd0, bus.ex_regWrite}, 32'd0);
        chk({tag, "_ex_isLoad"},   {31'd0, bus.ex_isLoad},   32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bus.flush     = 1'b0;
        bus.ex_ready  = 1'b1;
        bus.ex_result = 32'd0;
        mem_set(1'b0, 5'd0, 32'd0);
        drive_instr(5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 32'd0, ALU_ADD, 5'd0, 1'b0, 1'b0);
        bus.id_valid = 1'b0;

        // Reset state
        step();
        step();
        chk_all_zero("reset");

        // ADD x3 = x1 + x2 with RF values 8, 8
        #2 reset = 1'b1;
        drive_instr(5'd1, 32'd8, 5'd2, 32'd8, 1'b0, 32'd0, ALU_ADD, 5'd3, 1'b1, 1'b0);
        #1 chk("add_id_ready", {31'd0, bus.id_ready}, 32'd1);
        step();
        chk("add_inputA",   bus.inputA, 32'd8);
        chk("add_inputB",   bus.inputB, 32'd8);
        chk("add_sel",      {28'd0, bus.ALUSelect}, 32'd0);
        chk("add_ex_valid", {31'd0, bus.ex_valid}, 32'd1);
        chk("add_ex_rd",    {27'd0, bus.ex_rd}, 32'd3);

        // SUB x4 = x3 - x1: x3 from held result 16, beating a stale memory-stage x3
        bus.ex_result = 32'd16;
        mem_set(1'b1, 5'd3, 32'd99);
        drive_instr(5'd3, 32'd0, 5'd1, 32'd8, 1'b0, 32'd0, ALU_SUB, 5'd4, 1'b1, 1'b0);
        step();
        chk("b2b_inputA", bus.inputA, 32'd16);
        chk("b2b_inputB", bus.inputB, 32'd8);
        chk("b2b_sel",    {28'd0, bus.ALUSelect}, 32'd1);

        // LW x5, 4(x2)
        bus.ex_result = 32'd8;
        mem_set(1'b0, 5'd0, 32'd0);
        drive_instr(5'd2, 32'd8, 5'd0, 32'd0, 1'b1, 32'd4, ALU_ADD, 5'd5, 1'b1, 1'b1);
        step();
        chk("lw_inputA",    bus.inputA, 32'd8);
        chk("lw_inputB",    bus.inputB, 32'd4);
        chk("lw_ex_isLoad", {31'd0, bus.ex_isLoad}, 32'd1);

        // ADD x6 = x5 + x1: load-use, one bubble
        bus.ex_result = 32'd12;
        drive_instr(5'd5, 32'd0, 5'd1, 32'd8, 1'b0, 32'd0, ALU_ADD, 5'd6, 1'b1, 1'b0);
        #1 chk("lu_id_ready", {31'd0, bus.id_ready}, 32'd0);
        step();
        chk("lu_bubble_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("lu_bubble_rw",    {31'd0, bus.ex_regWrite}, 32'd0);
        mem_set(1'b1, 5'd5, 32'h8000_0009);
        #1 chk("lu_id_ready2", {31'd0, bus.id_ready}, 32'd1);
        step();
        chk("lu_inputA",   bus.inputA, 32'h8000_0009);
        chk("lu_inputB",   bus.inputB, 32'd8);
        chk("lu_ex_valid", {31'd0, bus.ex_valid}, 32'd1);

        // x0 guard: held rd=0 writes 7, memory stage also claims x0
        mem_set(1'b0, 5'd0, 32'd0);
        drive_instr(5'd1, 32'd8, 5'd2, 32'd8, 1'b0, 32'd0, ALU_ADD, 5'd0, 1'b1, 1'b0);
        step();
        bus.ex_result = 32'd7;
        mem_set(1'b1, 5'd0, 32'd55);
        drive_instr(5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 32'd0, ALU_ADD, 5'd7, 1'b1, 1'b0);
        step();
        chk("x0_inputA", bus.inputA, 32'd0);
        chk("x0_inputB", bus.inputB, 32'd0);

        // LW x9 held, then ORI x10 = x1 | 7 with rs2 field = 9 under a 3-cycle stall
        mem_set(1'b0, 5'd0, 32'd0);
        drive_instr(5'd1, 32'd8, 5'd0, 32'd0, 1'b1, 32'd0, ALU_ADD, 5'd9, 1'b1, 1'b1);
        step();
        bus.ex_ready = 1'b0;
        drive_instr(5'd1, 32'd8, 5'd9, 32'd0, 1'b1, 32'd7, ALU_OR, 5'd10, 1'b1, 1'b0);
        #1 chk("ori_stall_id_ready", {31'd0, bus.id_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ori_hold_rd",     {27'd0, bus.ex_rd}, 32'd9);
            chk("ori_hold_isLoad", {31'd0, bus.ex_isLoad}, 32'd1);
            chk("ori_hold_inputB", bus.inputB, 32'd0);
        end
        bus.ex_ready = 1'b1;
        #1 chk("ori_id_ready", {31'd0, bus.id_ready}, 32'd1);
        step();
        chk("ori_inputA", bus.inputA, 32'd8);
        chk("ori_inputB", bus.inputB, 32'd7);
        chk("ori_sel",    {28'd0, bus.ALUSelect}, 32'd4);
        chk("ori_valid",  {31'd0, bus.ex_valid}, 32'd1);

        // Flush together with a stall kills the held instruction
        bus.flush    = 1'b1;
        bus.ex_ready = 1'b0;
        drive_instr(5'd1, 32'd8, 5'd2, 32'd8, 1'b0, 32'd0, ALU_XOR, 5'd11, 1'b1, 1'b0);
        #1 chk("flush_id_ready", {31'd0, bus.id_ready}, 32'd0);
        step();
        chk("flush_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        bus.flush    = 1'b0;
        bus.ex_ready = 1'b1;

        // Hazard pending during a stall: hold, then bubble once released
        drive_instr(5'd1, 32'd8, 5'd0, 32'd0, 1'b1, 32'd0, ALU_ADD, 5'd12, 1'b1, 1'b1);
        step();
        bus.ex_ready = 1'b0;
        drive_instr(5'd0, 32'd0, 5'd12, 32'd0, 1'b0, 32'd0, ALU_ADD, 5'd13, 1'b1, 1'b0);
        step();
        chk("hz_hold_valid",  {31'd0, bus.ex_valid}, 32'd1);
        chk("hz_hold_isLoad", {31'd0, bus.ex_isLoad}, 32'd1);
        bus.ex_ready = 1'b1;
        #1 chk("hz_id_ready", {31'd0, bus.id_ready}, 32'd0);
        step();
        chk("hz_bubble", {31'd0, bus.ex_valid}, 32'd0);

        // Reset asserted mid-stall clears everything asynchronously
        drive_instr(5'd1, 32'd8, 5'd2, 32'd8, 1'b0, 32'd0, ALU_MUL, 5'd14, 1'b1, 1'b0);
        step();
        bus.ex_ready = 1'b0;
        step();
        #2 reset = 1'b0;
        #1 chk_all_zero("midreset");
        bus.id_valid = 1'b0;
        step();
        reset = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
